// File: rtl/slv_guard_cfg_pkg.sv
// rtl/slv_guard_cfg_pkg.sv - shared types and default register table for the guard config sequencer
package slv_guard_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    GAP,
    DONE,
    ERR
  } cfg_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;

  localparam int unsigned NumGuardRegs = 11;

  localparam logic [31:0] GuardEnaOffs  = 32'h00;
  localparam logic [31:0] AwVldBudgOffs = 32'h04;
  localparam logic [31:0] AwRdyBudgOffs = 32'h08;
  localparam logic [31:0] WLastBudgOffs = 32'h0c;
  localparam logic [31:0] BVldBudgOffs  = 32'h10;
  localparam logic [31:0] BRdyBudgOffs  = 32'h14;
  localparam logic [31:0] ArVldBudgOffs = 32'h18;
  localparam logic [31:0] ArRdyBudgOffs = 32'h1c;
  localparam logic [31:0] RVldBudgOffs  = 32'h20;
  localparam logic [31:0] RRdyBudgOffs  = 32'h24;
  localparam logic [31:0] RLastBudgOffs = 32'h28;

  // Leftmost element is entry NumGuardRegs-1.
  localparam logic [NumGuardRegs-1:0][31:0] DefaultAddr = {
    RLastBudgOffs, RRdyBudgOffs, RVldBudgOffs, ArRdyBudgOffs, ArVldBudgOffs,
    BRdyBudgOffs, BVldBudgOffs, WLastBudgOffs, AwRdyBudgOffs, AwVldBudgOffs,
    GuardEnaOffs
  };

  localparam logic [NumGuardRegs-1:0][31:0] DefaultData = {
    {5{32'h0000_0001}}, 32'h0000_0100, {4{32'h0000_0300}}, 32'h0000_0100
  };

endpackage

// File: rtl/slv_guard_cfg_seq.sv
// rtl/slv_guard_cfg_seq.sv - boot-time register table writer with readback verify and retry
module slv_guard_cfg_seq
  import slv_guard_cfg_pkg::*;
#(
  parameter int unsigned AddrWidth  = 32,
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned StrbWidth  = DataWidth / 8,
  parameter int unsigned NumEntries = 11,
  parameter logic [NumEntries-1:0][AddrWidth-1:0] CfgAddr = DefaultAddr,
  parameter logic [NumEntries-1:0][DataWidth-1:0] CfgData = DefaultData,
  parameter logic [NumEntries-1:0][StrbWidth-1:0] CfgStrb = '1,
  parameter bit          Verify     = 1'b1,
  parameter int unsigned MaxRetries = 2,
  parameter bit          AutoStart  = 1'b1,
  parameter type reg_req_t = slv_guard_cfg_pkg::reg_req_t,
  parameter type reg_rsp_t = slv_guard_cfg_pkg::reg_rsp_t,
  localparam int unsigned IdxWidth = (NumEntries > 1) ? $clog2(NumEntries) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  output reg_req_t            reg_req_o,
  input  reg_rsp_t            reg_rsp_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic [IdxWidth-1:0] err_idx_o
);

  localparam int unsigned RetryWidth = (MaxRetries > 0) ? $clog2(MaxRetries + 1) : 1;

  cfg_state_e            state_q;
  logic [IdxWidth-1:0]   idx_q;
  logic [RetryWidth-1:0] retry_q;
  logic                  retry_gap_q;
  logic                  boot_q;
  logic                  auto_q;

  logic [DataWidth-1:0]  mask;
  logic                  hs, ok, fail, last_entry, can_retry;

  function automatic reg_req_t wr_req(input logic [IdxWidth-1:0] i);
    reg_req_t r;
    r       = '0;
    r.valid = 1'b1;
    r.write = 1'b1;
    r.addr  = CfgAddr[i];
    r.wdata = CfgData[i];
    r.wstrb = CfgStrb[i];
    return r;
  endfunction

  always_comb begin
    mask = '0;
    for (int b = 0; b < StrbWidth; b++) begin
      mask[8*b +: 8] = {8{CfgStrb[idx_q][b]}};
    end
  end

  assign hs         = reg_req_o.valid & reg_rsp_i.ready;
  assign last_entry = (idx_q == IdxWidth'(NumEntries - 1));
  assign can_retry  = (32'(retry_q) < MaxRetries);

  // Outcome of the current attempt, only meaningful on a handshake.
  always_comb begin
    ok   = 1'b0;
    fail = 1'b0;
    if (hs) begin
      if (state_q == WR) begin
        ok   = !reg_rsp_i.error;
        fail = reg_rsp_i.error;
      end else if (state_q == RD) begin
        ok   = !reg_rsp_i.error && (((reg_rsp_i.rdata ^ CfgData[idx_q]) & mask) == '0);
        fail = !ok;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      retry_q     <= '0;
      retry_gap_q <= 1'b0;
      boot_q      <= 1'b0;
      auto_q      <= AutoStart;
      reg_req_o   <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      err_idx_o   <= '0;
    end else begin
      boot_q <= 1'b1;
      case (state_q)
        IDLE: begin
          // boot_q delays the automatic start to the first cycle after release.
          if (start_i || (auto_q && boot_q)) begin
            auto_q    <= 1'b0;
            idx_q     <= '0;
            retry_q   <= '0;
            done_o    <= 1'b0;
            err_o     <= 1'b0;
            err_idx_o <= '0;
            busy_o    <= 1'b1;
            reg_req_o <= wr_req('0);
            state_q   <= WR;
          end
        end
        WR, RD: begin
          if (ok && state_q == WR && Verify) begin
            reg_req_o.write <= 1'b0;
            reg_req_o.wdata <= '0;
            reg_req_o.wstrb <= '0;
            state_q         <= RD;
          end else if (ok) begin
            reg_req_o   <= '0;
            retry_gap_q <= 1'b0;
            state_q     <= GAP;
          end else if (fail && can_retry) begin
            reg_req_o   <= '0;
            retry_q     <= retry_q + 1'b1;
            retry_gap_q <= 1'b1;
            state_q     <= GAP;
          end else if (fail) begin
            reg_req_o <= '0;
            busy_o    <= 1'b0;
            err_o     <= 1'b1;
            err_idx_o <= idx_q;
            state_q   <= IDLE;
          end
        end
        GAP: begin
          if (retry_gap_q) begin
            reg_req_o <= wr_req(idx_q);
            state_q   <= WR;
          end else if (last_entry) begin
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
            state_q <= IDLE;
          end else begin
            idx_q     <= idx_q + 1'b1;
            retry_q   <= '0;
            reg_req_o <= wr_req(idx_q + 1'b1);
            state_q   <= WR;
          end
        end
        default: begin
          reg_req_o <= '0;
          busy_o    <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/slv_guard_cfg_seq.md
# slv_guard_cfg_seq

Boot-time configuration sequencer for `slv_guard_top`. After reset or on a start pulse, it walks a parameter table of (address, data, strobe) entries and issues one register-bus write per entry to the guard's config port. Each write can optionally be read back and compared. Writes that get an error response, or fail the comparison, are retried. When the table is finished the block reports done or the index of the failing entry. In the SoC it replaces the software or testbench driver that programs the enable bit and the eleven budget registers (offsets 0x00–0x28).

## Interface
- `AddrWidth`, 32: register-bus address width.
- `DataWidth`, 32: register-bus data width. `StrbWidth = DataWidth/8`.
- `NumEntries`, 11: number of table entries. Must be ≥1.
- `CfgAddr`, `slv_guard_cfg_pkg::DefaultAddr`: `logic [NumEntries-1:0][AddrWidth-1:0]`, target address per entry.
- `CfgData`, `slv_guard_cfg_pkg::DefaultData`: per-entry write data.
- `CfgStrb`, all ones: per-entry byte strobe.
- `Verify`, 1'b1: read back each entry after writing it and compare under the strobe mask.
- `MaxRetries`, 2: extra attempts per entry after the first attempt fails.
- `AutoStart`, 1'b1: begin the sequence on the first cycle after reset is released.
- `reg_req_t`, `reg_rsp_t`: REG_BUS request and response structs (`addr`, `write`, `wdata`, `wstrb`, `valid` / `rdata`, `error`, `ready`).

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous, active-low reset.
- `start_i` in 1: one-cycle pulse that starts or restarts the sequence. Ignored while `busy_o`.
- `reg_req_o` out `reg_req_t`: register-bus request to `slv_guard_top.reg_req_i`.
- `reg_rsp_i` in `reg_rsp_t`: register-bus response.
- `busy_o` out 1: a sequence is in progress.
- `done_o` out 1: all entries were written (and verified, if enabled). Sticky until the next start.
- `err_o` out 1: the sequence aborted. Sticky until the next start.
- `err_idx_o` out `$clog2(NumEntries)` bits (minimum 1): index of the failing entry.

## Operation
- FSM states: IDLE, WR, RD, GAP, DONE, ERR.
- IDLE → WR on `start_i`, or on the first post-reset cycle when `AutoStart` is set.
  - Clears `idx`, `retry_cnt`, `done_o`, `err_o`.
- WR: drive `valid=1`, `write=1`, `addr=CfgAddr[idx]`, `wdata=CfgData[idx]`, `wstrb=CfgStrb[idx]`. Hold all fields stable until `ready`.
  - Handshake with `error=0`: go to RD if `Verify`, else GAP.
  - Handshake with `error=1`: the attempt fails.
- RD: `valid=1`, `write=0`, same `addr`, `wstrb=0`. Hold until `ready`.
  - Pass when `error=0` and `(rdata ^ CfgData[idx]) & mask == 0`, where `mask` expands each `wstrb` bit to 8 data bits. A pass goes to GAP.
  - Any other outcome is a failed attempt.
- Failed attempt:
  - If `retry_cnt < MaxRetries`: increment `retry_cnt` and go to GAP, then back to WR with the same `idx`.
  - Otherwise: go to ERR with `err_idx_o = idx`.
- GAP: `valid=0` for exactly one cycle.
  - On a retry, return to WR with the same `idx`.
  - On success, if `idx == NumEntries-1` go to DONE; otherwise increment `idx`, clear `retry_cnt`, and go to WR.
- DONE and ERR: set `done_o` or `err_o` respectively, drop `busy_o`, and return to IDLE in the same transition. The flags stay set until the next start.
- `busy_o` = 1 in WR, RD and GAP.
- `err_idx_o` holds its value until the next start.
- `retry_cnt` width is `$clog2(MaxRetries+1)`, minimum 1. `idx` never wraps.

## Timing
- Reset values: `reg_req_o` all fields 0, `busy_o` 0, `done_o` 0, `err_o` 0, `err_idx_o` 0. FSM resets to IDLE.
- Reset asserted mid-transaction drops `valid` immediately (asynchronous) with no completion.
- Start latency:
  - `start_i` in cycle t → `valid` and `busy_o` high in cycle t+1.
  - With `AutoStart`, `valid` rises in the second clock edge after `rst_ni` is released.
- All outputs are registered. Requests are issued one at a time, with no outstanding pipelining.
- Per-entry cycle cost with `ready` tied high, all entries passing:
  - Verify=1: 3 cycles (WR, RD, GAP).
  - Verify=0: 2 cycles (WR, GAP).
- Sequence length with `ready` tied high: `done_o` rises `3*NumEntries` cycles after the start edge (Verify=1), or `2*NumEntries` (Verify=0).
- A `start_i` in the same cycle that DONE or ERR returns to IDLE is ignored. `start_i` is accepted from the next cycle.
- `reg_rsp_i` is ignored whenever `valid=0`.

## Structure
- Package `slv_guard_cfg_pkg`:
  - the state enum `cfg_state_e`;
  - `NumGuardRegs = 11`;
  - register offset constants `GuardEnaOffs = 'h00` … `RLastBudgOffs = 'h28`;
  - `DefaultAddr` and `DefaultData` tables (enable = 0x100, write budgets = 0x300, b_ready budget = 0x100, read budgets = 0x1).
- No sub-module. The datapath is a table mux plus two counters.

## Test plan
- Default table, `ready` tied high, Verify=1, simple reg-file model → 11 writes at 0x00–0x28 and 11 reads, `done_o` 33 cycles after the start edge, `err_o`=0.
- `ready` delayed 4 cycles per transaction → request fields stable for 5 cycles each, one `valid=0` cycle between transactions, correct final register contents.
- Model returns `error=1` on the first write to 0x0c only → entry 3 rewritten once, sequence completes with `done_o`=1.
- Model corrupts readback of 0x1c for every attempt, MaxRetries=2 → 3 write/read pairs to 0x1c, then `err_o`=1, `err_idx_o`=7, `busy_o`=0, no access to 0x20.
- Reset asserted while WR waits for `ready` → `valid` drops without a clock edge. AutoStart restarts the sequence at entry 0 after release.
- `start_i` pulsed while `busy_o` is high → ignored, no restart. Pulsed after `err_o` → `err_o` and `err_idx_o` cleared, sequence reruns from entry 0.
